// File: rtl/spi_memory_pkg.sv
// spi_memory shared definitions.
// FSM state encoding and byte/address widths.
package spi_memory_pkg;

    localparam int ADDR_W = 7;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        GET_ADDR  = 3'd0,
        GOT_ADDR  = 3'd1,
        READ_LOAD = 3'd2,
        READ      = 3'd3,
        WRITE     = 3'd4,
        WRITE_MEM = 3'd5,
        DONE      = 3'd6
    } state_e;

endpackage

// File: rtl/spi_memory_if.sv
// SPI pin bundle driven by the master.
// MISO is a tri-state pin and stays a plain port on the top.
interface spi_memory_if;

    logic sclk_pin;
    logic cs_pin;
    logic mosi_pin;

    modport master (
        output sclk_pin,
        output cs_pin,
        output mosi_pin
    );

    modport slave (
        input sclk_pin,
        input cs_pin,
        input mosi_pin
    );

endinterface

// File: rtl/spi_memory_input_conditioner.sv
// Synchronizer + debouncer for one asynchronous pin.
// Emits one-clock pulses on conditioned rising/falling edges.
module input_conditioner
    import spi_memory_pkg::*;
#(
    parameter int   WAIT_TIME = 3,
    parameter logic INIT      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy_i,
    output logic clean_o,
    output logic pos_o,
    output logic neg_o
);

    localparam int CW = $clog2(WAIT_TIME + 1);

    logic [1:0]    sync_q;
    logic          clean_q;
    logic          clean_d;
    logic          pos_q;
    logic          pos_d;
    logic          neg_q;
    logic          neg_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Two-flop synchronizer, reset to the pin's idle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {INIT, INIT};
        end else begin
            sync_q <= {sync_q[0], noisy_i};
        end
    end

    // Accept a new level only after WAIT_TIME consecutive mismatches
    always_comb begin
        clean_d = clean_q;
        cnt_d   = '0;
        pos_d   = 1'b0;
        neg_d   = 1'b0;
        if (sync_q[1] != clean_q) begin
            if (cnt_q == CW'(WAIT_TIME - 1)) begin
                clean_d = sync_q[1];
                pos_d   = sync_q[1];
                neg_d   = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Conditioned level, mismatch counter and edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean_q <= INIT;
            cnt_q   <= '0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
        end
    end

    assign clean_o = clean_q;
    assign pos_o   = pos_q;
    assign neg_o   = neg_q;

endmodule

// File: rtl/spi_memory.sv
// SPI mode-0 slave holding a 2**ADDR_W x 8 byte memory.
// Frame: command byte {addr, rw}, then one data byte in or out.
module spi_memory #(
    parameter int WAIT_TIME = 3,
    parameter int ADDR_W    = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_memory_if.slave             spi,
    input  logic                    faultinjector_pin,
    output logic                    miso_pin,
    output logic [7:0]              leds
);

    import spi_memory_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;

    logic cs_cond;
    logic sclk_pos;
    logic sclk_neg;
    logic mosi_cond;

    logic unused_cs_pos;
    logic unused_cs_neg;
    logic unused_sclk_cond;
    logic unused_mosi_pos;
    logic unused_mosi_neg;
    logic unused_fault;

    logic [BYTE_W-1:0] pout_q;
    logic [BYTE_W-1:0] pout_d;
    logic [BYTE_W-1:0] addr_q;
    logic [BYTE_W-1:0] dout;
    logic [ADDR_W-1:0] mem_addr;
    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic              miso_q;

    state_e            state_q;
    state_e            state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic              last_bit;

    logic              addr_we;
    logic              sr_we;
    logic              dm_we;
    logic              miso_en;

    assign unused_fault = faultinjector_pin;

    input_conditioner #(.WAIT_TIME(WAIT_TIME), .INIT(1'b1)) u_cs (
        .clk     (clk),
        .rst_n   (rst_n),
        .noisy_i (spi.cs_pin),
        .clean_o (cs_cond),
        .pos_o   (unused_cs_pos),
        .neg_o   (unused_cs_neg)
    );

    input_conditioner #(.WAIT_TIME(WAIT_TIME), .INIT(1'b0)) u_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .noisy_i (spi.sclk_pin),
        .clean_o (unused_sclk_cond),
        .pos_o   (sclk_pos),
        .neg_o   (sclk_neg)
    );

    input_conditioner #(.WAIT_TIME(WAIT_TIME), .INIT(1'b0)) u_mosi (
        .clk     (clk),
        .rst_n   (rst_n),
        .noisy_i (spi.mosi_pin),
        .clean_o (mosi_cond),
        .pos_o   (unused_mosi_pos),
        .neg_o   (unused_mosi_neg)
    );

    assign mem_addr = addr_q[ADDR_W:1];
    assign dout     = mem_q[mem_addr];
    assign last_bit = sclk_pos && (cnt_q == 4'(BYTE_W - 1));

    // Shift register: memory load wins over an SCLK shift
    always_comb begin
        pout_d = pout_q;
        if (sr_we) begin
            pout_d = dout;
        end else if (sclk_pos) begin
            pout_d = {pout_q[BYTE_W-2:0], mosi_cond};
        end
    end

    // Shift register, command latch and MISO flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pout_q <= '0;
            addr_q <= '0;
            miso_q <= 1'b0;
        end else begin
            pout_q <= pout_d;
            if (addr_we) begin
                addr_q <= pout_q;
            end
            if (sclk_neg) begin
                miso_q <= pout_q[BYTE_W-1];
            end
        end
    end

    // Byte memory, contents survive reset
    always_ff @(posedge clk) begin
        if (dm_we) begin
            mem_q[mem_addr] <= pout_q;
        end
    end

    // FSM state and SCLK-rise counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GET_ADDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: CS high aborts the frame from any state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cs_cond) begin
            state_d = GET_ADDR;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                GET_ADDR: begin
                    if (sclk_pos) cnt_d = cnt_q + 4'd1;
                    if (last_bit) state_d = GOT_ADDR;
                end
                GOT_ADDR: begin
                    cnt_d   = '0;
                    state_d = pout_q[0] ? READ_LOAD : WRITE;
                end
                READ_LOAD: state_d = READ;
                READ: begin
                    if (sclk_pos) cnt_d = cnt_q + 4'd1;
                    if (last_bit) state_d = DONE;
                end
                WRITE: begin
                    if (sclk_pos) cnt_d = cnt_q + 4'd1;
                    if (last_bit) state_d = WRITE_MEM;
                end
                WRITE_MEM: state_d = DONE;
                DONE:      state_d = DONE;
                default:   state_d = GET_ADDR;
            endcase
        end
    end

    // Per-state strobes, all forced low while CS is high
    always_comb begin
        addr_we = 1'b0;
        sr_we   = 1'b0;
        dm_we   = 1'b0;
        miso_en = 1'b0;
        if (!cs_cond) begin
            unique case (state_q)
                GOT_ADDR:  addr_we = 1'b1;
                READ_LOAD: sr_we   = 1'b1;
                READ:      miso_en = 1'b1;
                WRITE_MEM: dm_we   = 1'b1;
                default:   ;
            endcase
        end
    end

    assign miso_pin = miso_en ? miso_q : 1'bz;
    assign leds     = addr_q;

endmodule

// File: tb/tb_spi_memory.sv
// Bench for spi_memory: directed table, hand sequences, random traffic.
// MISO has a pull-up here, so a released pin reads as 1.
module tb_spi_memory;

    import spi_memory_pkg::*;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fi = 1'b0;
    wire        miso_w;
    logic [7:0] leds;

    pullup (miso_w);

    spi_memory_if spi_if ();

    spi_memory dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .spi               (spi_if),
        .faultinjector_pin (fi),
        .miso_pin          (miso_w),
        .leds              (leds)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit mon_z = 1'b0;
    bit z_bad = 1'b0;

    logic [7:0] ref_mem [128];
    bit         ref_ok  [128];

    typedef struct {
        string      name;
        logic [7:0] cmd;
        logic [7:0] wdat;
        int         nbits;
        int         glitch;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    task automatic check8(input string nm, input logic [7:0] act,
                          input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act,
                          input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Advance n clocks, flagging any driven-low MISO while monitoring
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (mon_z && miso_w !== 1'b1) z_bad = 1'b1;
        end
    endtask

    // Mode-0 master frame; MISO is sampled mid-high-phase to cover
    // the slave's conditioner latency on the preceding fall.
    task automatic frame(input logic [7:0] cmd, input logic [7:0] wdat,
                         input int nbits, input int glitch_after,
                         input bit keep_cs, output logic [7:0] rdat);
        logic [15:0] tx;
        logic [3:0]  c0;
        logic [7:0]  p0;
        tx = {cmd, wdat};
        rdat = '0;
        spi_if.cs_pin = 1'b0;
        spi_if.sclk_pin = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_if.mosi_pin = tx[15-i];
            tick(HALF);
            spi_if.sclk_pin = 1'b1;
            tick(3);
            if (i >= 8) rdat = {rdat[6:0], miso_w};
            tick(HALF - 3);
            spi_if.sclk_pin = 1'b0;
            if (i == glitch_after) begin
                tick(HALF + 1);
                c0 = dut.cnt_q;
                p0 = dut.pout_q;
                spi_if.sclk_pin = 1'b1;
                tick(2);
                spi_if.sclk_pin = 1'b0;
                tick(HALF + 2);
                check8("glitch_cnt", 8'(dut.cnt_q), 8'(c0));
                check8("glitch_pout", dut.pout_q, p0);
            end
        end
        if (!keep_cs) begin
            tick(HALF);
            spi_if.cs_pin = 1'b1;
            tick(12);
        end
    endtask

    // Run one full-or-aborted frame and check it against the model
    task automatic run(input string nm, input logic [7:0] cmd,
                       input logic [7:0] wdat, input int nbits,
                       input int glitch);
        logic [7:0] rd;
        logic [6:0] a;
        a = cmd[7:1];
        z_bad = 1'b0;
        mon_z = !cmd[0];
        frame(cmd, wdat, nbits, glitch, 1'b0, rd);
        mon_z = 1'b0;
        check8({nm, "_leds"}, leds, cmd);
        if (cmd[0]) begin
            if (ref_ok[a]) check8({nm, "_rdata"}, rd, ref_mem[a]);
            check1({nm, "_miso_z_after"}, miso_w, 1'b1);
        end else begin
            check1({nm, "_miso_z_write"}, z_bad, 1'b0);
            if (nbits == 16) begin
                ref_mem[a] = wdat;
                ref_ok[a]  = 1'b1;
            end
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic [6:0] last_a;
        logic [6:0] a;
        logic [7:0] d;
        int         nb;

        for (int i = 0; i < 128; i++) ref_ok[i] = 1'b0;

        vecs[0] = '{"wr1",      8'h02, 8'h55, 16, -1, 8'h00};
        vecs[1] = '{"rd1",      8'h03, 8'h00, 16, -1, 8'h55};
        vecs[2] = '{"wr0",      8'h00, 8'h3C, 16, -1, 8'h00};
        vecs[3] = '{"wr127",    8'hFE, 8'hA3, 16, -1, 8'h00};
        vecs[4] = '{"rd127",    8'hFF, 8'h00, 16, -1, 8'hA3};
        vecs[5] = '{"rd0",      8'h01, 8'h00, 16, -1, 8'h3C};
        vecs[6] = '{"wr5",      8'h0A, 8'h11, 16, -1, 8'h00};
        vecs[7] = '{"abort5",   8'h0A, 8'hEE, 12, -1, 8'h00};
        vecs[8] = '{"rd5_glt",  8'h0B, 8'h00, 16,  3, 8'h11};
        vecs[9] = '{"rd1_glt",  8'h03, 8'h00, 16,  5, 8'h55};

        spi_if.cs_pin   = 1'b1;
        spi_if.sclk_pin = 1'b0;
        spi_if.mosi_pin = 1'b0;
        tick(3);
        check8("rst_leds", leds, 8'h00);
        check1("rst_miso_z", miso_w, 1'b1);
        check8("rst_state", 8'(dut.state_q), 8'(GET_ADDR));
        rst_n = 1'b1;
        tick(5);

        // Directed table: table expectations and the model must agree
        foreach (vecs[k]) begin
            run(vecs[k].name, vecs[k].cmd, vecs[k].wdat,
                vecs[k].nbits, vecs[k].glitch);
            if (vecs[k].cmd[0])
                check8({vecs[k].name, "_table"},
                       ref_mem[vecs[k].cmd[7:1]], vecs[k].exp_rd);
        end

        // Reset in the middle of a read
        frame(8'h03, 8'h00, 10, -1, 1'b1, rd);
        tick(2);
        check8("pre_rst_state", 8'(dut.state_q), 8'(READ));
        rst_n = 1'b0;
        tick(2);
        check1("midrst_miso_z", miso_w, 1'b1);
        check8("midrst_leds", leds, 8'h00);
        check8("midrst_state", 8'(dut.state_q), 8'(GET_ADDR));
        rst_n = 1'b1;
        spi_if.cs_pin = 1'b1;
        spi_if.sclk_pin = 1'b0;
        tick(12);
        run("post_rst_rd1", 8'h03, 8'h00, 16, -1);

        // Random traffic against the array model
        last_a = 7'd1;
        for (int t = 0; t < 40; t++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                a = ($urandom_range(0, 2) != 0) ? last_a : 7'($urandom);
                run("rnd_rd", {a, 1'b1}, 8'h00, 16, -1);
            end else begin
                a  = 7'($urandom);
                nb = ($urandom_range(0, 4) == 0) ?
                     $urandom_range(9, 15) : 16;
                run("rnd_wr", {a, 1'b0}, d, nb, -1);
                if (nb == 16) last_a = a;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
